// File: rtl/bayer_gaussian_filter.sv
// Same-colour 3x3 Gaussian (or bypass) on a 5x5 raw Bayer window; top/left borders replicate the centre.
// Six registered stages; vsync/href are delayed to match; no backpressure, one pixel per href cycle.
module bayer_gaussian_filter #(
  parameter int BITS  = 8,
  parameter int WIDTH = 1936,
  parameter int COL_W = 12
) (
  input  logic            pclk,
  input  logic            rst_n,
  input  logic            in_vsync,
  input  logic            in_href,
  input  logic [BITS-1:0] in_data,
  input  logic [1:0]      cfg_mode,
  input  logic [1:0]      cfg_bayer,
  output logic            out_vsync,
  output logic            out_href,
  output logic [BITS-1:0] out_data
);
  localparam int AW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int LAT = 6;
  localparam logic [COL_W-1:0] CNT_MAX = '1;

  function automatic logic [7:0] coef(input logic [1:0] mode, input int cls);
    logic [7:0] c;
    case (mode)
      2'd1:    c = (cls == 0) ? 8'd104 : (cls == 1) ? 8'd118 : 8'd133;
      2'd2:    c = (cls == 0) ? 8'd109 : (cls == 1) ? 8'd115 : 8'd122;
      default: c = (cls == 0) ? 8'd76  : (cls == 1) ? 8'd126 : 8'd209;
    endcase
    return c;
  endfunction

  function automatic logic below(input logic [COL_W-1:0] v, input int lim);
    return (lim > 0) && (int'(v) < lim);
  endfunction

  logic             r_vs_d, r_href_d;
  logic [1:0]       r_mode, r_bayer;
  logic [COL_W-1:0] r_row, r_col;
  logic [AW-1:0]    r_addr;
  logic [LAT-1:0]   r_vs_dly, r_href_dly;
  logic             w_vs_rise, w_href_rise, w_href_fall;
  logic [COL_W-1:0] w_row, w_col;
  logic [AW-1:0]    w_addr;
  logic [1:0]       w_mode, w_bayer;

  // The pixel arriving with a vsync/href edge already belongs to the new frame/line.
  assign w_vs_rise   = in_vsync & ~r_vs_d;
  assign w_href_rise = in_href & ~r_href_d;
  assign w_href_fall = ~in_href & r_href_d;
  assign w_row   = w_vs_rise ? '0 : r_row;
  assign w_col   = w_href_rise ? '0 : r_col;
  assign w_addr  = w_href_rise ? '0 : r_addr;
  assign w_mode  = w_vs_rise ? cfg_mode : r_mode;
  assign w_bayer = w_vs_rise ? cfg_bayer : r_bayer;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_d     <= 1'b0;
      r_href_d   <= 1'b0;
      r_mode     <= 2'd0;
      r_bayer    <= 2'd0;
      r_row      <= '0;
      r_col      <= '0;
      r_addr     <= '0;
      r_vs_dly   <= '0;
      r_href_dly <= '0;
    end else begin
      r_vs_d     <= in_vsync;
      r_href_d   <= in_href;
      r_mode     <= w_mode;
      r_bayer    <= w_bayer;
      r_vs_dly   <= {r_vs_dly[LAT-2:0], in_vsync};
      r_href_dly <= {r_href_dly[LAT-2:0], in_href};
      if (w_vs_rise)
        r_row <= '0;
      else if (w_href_fall && r_row != CNT_MAX)
        r_row <= r_row + COL_W'(1);
      if (in_href) begin
        r_col  <= (w_col == CNT_MAX) ? w_col : w_col + COL_W'(1);
        r_addr <= (w_addr == AW'(WIDTH-1)) ? '0 : w_addr + AW'(1);
      end
    end
  end

  assign out_vsync = r_vs_dly[LAT-1];
  assign out_href  = r_href_dly[LAT-1];

  // Cascaded line buffers: buffer k holds row r-1-k at the current column.
  logic [BITS-1:0] r_lb [4][WIDTH];
  logic [BITS-1:0] w_lb_rd [4];

  always_comb begin
    for (int k = 0; k < 4; k++) w_lb_rd[k] = r_lb[k][w_addr];
  end

  always_ff @(posedge pclk) begin
    if (in_href) begin
      r_lb[0][w_addr] <= in_data;
      for (int k = 1; k < 4; k++) r_lb[k][w_addr] <= w_lb_rd[k-1];
    end
  end

  // Window r_win[i][j] = p(i+1)(j+1); column 4 is the newest pixel (r,c).
  logic [BITS-1:0]  r_win [5][5];
  logic [COL_W-1:0] r_s1_row, r_s1_col;
  logic [1:0]       r_s1_mode, r_s1_bayer;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++) r_win[i][j] <= '0;
      r_s1_row   <= '0;
      r_s1_col   <= '0;
      r_s1_mode  <= 2'd0;
      r_s1_bayer <= 2'd0;
    end else if (in_href) begin
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 4; j++) r_win[i][j] <= r_win[i][j+1];
      for (int i = 0; i < 4; i++) r_win[i][4] <= w_lb_rd[3-i];
      r_win[4][4] <= in_data;
      r_s1_row   <= w_row;
      r_s1_col   <= w_col;
      r_s1_mode  <= w_mode;
      r_s1_bayer <= w_bayer;
    end
  end

  logic [1:0] w_phase;
  logic       w_diamond, w_zero;
  assign w_phase   = r_s1_bayer ^ {r_s1_row[0], r_s1_col[0]};
  assign w_diamond = w_phase[1] ^ w_phase[0];
  assign w_zero    = below(r_s1_row, 2) || below(r_s1_col, 2);

  logic [1:0]      r_s2_mode;
  logic [BITS+7:0] w_prod [9];

  for (genvar a = 0; a < 3; a++) begin : g_ta
    for (genvar b = 0; b < 3; b++) begin : g_tb
      localparam bit CORNER = (a != 1) && (b != 1);
      localparam int CLS = CORNER ? 0 : ((a == 1) && (b == 1)) ? 2 : 1;
      localparam int SR  = 2 * a;
      localparam int SC  = 2 * b;
      localparam int DR  = CORNER ? a + 1 : 2 * a;
      localparam int DC  = CORNER ? b + 1 : 2 * b;
      logic [BITS-1:0] w_pix;
      logic            w_oob;
      logic [BITS-1:0] r_tap;
      logic [BITS+7:0] r_prod;

      // Tap (ri,ci) sits at frame row r-4+ri; above/left of the frame it takes p33.
      assign w_pix = w_diamond ? r_win[DR][DC] : r_win[SR][SC];
      assign w_oob = w_diamond ? (below(r_s1_row, 4 - DR) || below(r_s1_col, 4 - DC))
                               : (below(r_s1_row, 4 - SR) || below(r_s1_col, 4 - SC));

      always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
          r_tap  <= '0;
          r_prod <= '0;
        end else begin
          r_tap  <= w_oob ? r_win[2][2] : w_pix;
          r_prod <= (BITS+8)'(r_tap) * (BITS+8)'(coef(r_s2_mode, CLS));
        end
      end
      assign w_prod[3*a+b] = r_prod;
    end
  end

  // Side band per stage: {zero, bypass, p33}.
  logic [BITS+1:0]  r_side [2:5];
  logic [BITS+9:0]  r_rsum [3];
  logic [BITS+11:0] r_total;
  logic [BITS:0]    w_rnd;
  logic             w_sat;
  logic [BITS-1:0]  w_filt;
  logic             w_unused;

  assign w_rnd    = {1'b0, r_total[BITS+9:10]} + (BITS+1)'(r_total[9]);
  assign w_sat    = (|r_total[BITS+11:BITS+10]) | w_rnd[BITS];
  assign w_filt   = w_sat ? '1 : w_rnd[BITS-1:0];
  assign w_unused = ^{r_total[8:0], r_win[1][0], r_win[3][0]};

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_mode <= 2'd0;
      for (int k = 2; k <= 5; k++) r_side[k] <= '0;
      for (int a = 0; a < 3; a++) r_rsum[a] <= '0;
      r_total  <= '0;
      out_data <= '0;
    end else begin
      r_s2_mode <= r_s1_mode;
      r_side[2] <= {w_zero, (r_s1_mode == 2'd3), r_win[2][2]};
      for (int k = 3; k <= 5; k++) r_side[k] <= r_side[k-1];
      for (int a = 0; a < 3; a++)
        r_rsum[a] <= (BITS+10)'(w_prod[3*a]) + (BITS+10)'(w_prod[3*a+1])
                   + (BITS+10)'(w_prod[3*a+2]);
      r_total  <= (BITS+12)'(r_rsum[0]) + (BITS+12)'(r_rsum[1]) + (BITS+12)'(r_rsum[2]);
      out_data <= r_side[5][BITS+1] ? '0 :
                  r_side[5][BITS]   ? r_side[5][BITS-1:0] : w_filt;
    end
  end
endmodule

// File: tb/tb_bayer_gaussian_filter.sv
// Directed frames (flat, impulse, ramp, random) against a spatial reference model through a scoreboard.
module tb_bayer_gaussian_filter;
  localparam int ROWS = 16;
  localparam int COLS = 20;

  logic       pclk = 1'b0;
  logic       rst_n;
  logic       in_vsync, in_href;
  logic [7:0] in_data;
  logic [1:0] cfg_mode, cfg_bayer;
  logic       out_vsync, out_href;
  logic [7:0] out_data;

  always #5 pclk = ~pclk;

  bayer_gaussian_filter #(.BITS(8), .WIDTH(1936), .COL_W(12)) dut (
    .pclk(pclk), .rst_n(rst_n), .in_vsync(in_vsync), .in_href(in_href), .in_data(in_data),
    .cfg_mode(cfg_mode), .cfg_bayer(cfg_bayer),
    .out_vsync(out_vsync), .out_href(out_href), .out_data(out_data)
  );

  typedef struct { logic [7:0] exp; int r; int c; } sb_t;
  sb_t sb_q[$];
  sb_t mon_e;
  int  img [ROWS][COLS];
  int  cap [ROWS][COLS];
  int  wtab [3][3] = '{'{76, 126, 209}, '{104, 118, 133}, '{109, 115, 122}};
  int  n_checks = 0;
  int  n_fail = 0;
  logic [5:0] hist_h, hist_v;

  always @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hist_h <= '0;
      hist_v <= '0;
    end else begin
      hist_h <= {hist_h[4:0], in_href};
      hist_v <= {hist_v[4:0], in_vsync};
    end
  end

  always @(negedge pclk) begin
    if (rst_n) begin
      n_checks++;
      assert (out_href === hist_h[5]) else begin
        n_fail++; $error("FAIL href_delay: got %b expected %b", out_href, hist_h[5]);
      end
      n_checks++;
      assert (out_vsync === hist_v[5]) else begin
        n_fail++; $error("FAIL vsync_delay: got %b expected %b", out_vsync, hist_v[5]);
      end
      if (out_href === 1'b1) begin
        n_checks++;
        assert (sb_q.size() > 0) else begin
          n_fail++; $error("FAIL sb_underflow: got 0 queued expected >0");
        end
        if (sb_q.size() > 0) begin
          mon_e = sb_q.pop_front();
          n_checks++;
          assert (out_data === mon_e.exp) else begin
            n_fail++;
            $error("FAIL pix(%0d,%0d): got %0d expected %0d", mon_e.r, mon_e.c, out_data, mon_e.exp);
          end
          if (mon_e.r >= 0 && mon_e.c >= 0) cap[mon_e.r][mon_e.c] = int'(out_data);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++; $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic idle(input int n);
    in_href = 1'b0;
    repeat (n) tick();
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int weight(input int ph, input int dy, input int dx, input int mode);
    bit diamond;
    diamond = (ph == 1) || (ph == 2);
    if (dy == 0 && dx == 0) return wtab[mode][2];
    if ((dy == 0 && iabs(dx) == 2) || (dx == 0 && iabs(dy) == 2)) return wtab[mode][1];
    if (diamond ? (iabs(dy) == 1 && iabs(dx) == 1) : (iabs(dy) == 2 && iabs(dx) == 2))
      return wtab[mode][0];
    return 0;
  endfunction

  function automatic logic [7:0] model(input int r, input int c, input int mode, input int bayer);
    int y, x, ph, sum, yy, xx, v, w;
    y = r - 2;
    x = c - 2;
    if (y < 0 || x < 0) return 8'd0;
    if (mode == 3) return 8'(img[y][x]);
    ph  = bayer ^ (((y & 1) << 1) | (x & 1));
    sum = 0;
    for (int dy = -2; dy <= 2; dy++) begin
      for (int dx = -2; dx <= 2; dx++) begin
        w  = weight(ph, dy, dx, mode);
        yy = y + dy;
        xx = x + dx;
        v  = (yy < 0 || xx < 0) ? img[y][x] : img[yy][xx];
        sum += w * v;
      end
    end
    v = (sum + 512) >> 10;
    return (v > 255) ? 8'd255 : 8'(v);
  endfunction

  task automatic set_img(input int kind);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        case (kind)
          0: img[r][c] = 100;
          1: img[r][c] = (r == 10 && c == 10) ? 255 : 0;
          2: img[r][c] = c;
          default: img[r][c] = int'($urandom_range(255));
        endcase
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_href", 32'(out_href), 0);
    chk("rst_mid_vsync", 32'(out_vsync), 0);
    chk("rst_mid_data", 32'(out_data), 0);
    in_href  = 1'b0;
    in_vsync = 1'b0;
    sb_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  // Latched config is fmode/fbayer; mid_mode >= 0 changes cfg_mode partway through the frame.
  task automatic drive_frame(input int fmode, input int fbayer, input bit gaps, input bit vs_join,
                             input int mid_mode, input int abort_r);
    sb_t e;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) cap[r][c] = -1;
    cfg_mode  = 2'(fmode);
    cfg_bayer = 2'(fbayer);
    if (!vs_join) begin
      in_vsync = 1'b1;
      repeat (2) tick();
      in_vsync = 1'b0;
      idle(gaps ? 7 : 3);
    end
    for (int r = 0; r < ROWS; r++) begin
      if (mid_mode >= 0 && r == 2) cfg_mode = 2'(mid_mode);
      for (int c = 0; c < COLS; c++) begin
        if (r == abort_r && c == 7) begin
          do_reset();
          return;
        end
        if (vs_join && r == 0 && c == 0) in_vsync = 1'b1;
        in_href = 1'b1;
        in_data = 8'(img[r][c]);
        e.exp = model(r, c, fmode, fbayer);
        e.r   = r - 2;
        e.c   = c - 2;
        sb_q.push_back(e);
        tick();
        in_vsync = 1'b0;
      end
      idle(!gaps ? 2 : (r == 1) ? 1 : (r == 3) ? 300 : (r == 5) ? 7 : 2);
    end
    idle(10);
  endtask

  initial begin
    rst_n = 1'b0; in_vsync = 1'b0; in_href = 1'b0; in_data = '0;
    cfg_mode = 2'd0; cfg_bayer = 2'd0;
    repeat (3) tick();
    chk("reset_href", 32'(out_href), 0);
    chk("reset_vsync", 32'(out_vsync), 0);
    chk("reset_data", 32'(out_data), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    set_img(0);
    drive_frame(0, 0, 0, 0, -1, -1);
    chk("flat_c22", 32'(cap[2][2]), 99);
    chk("flat_c23", 32'(cap[2][3]), 99);
    chk("flat_c32", 32'(cap[3][2]), 99);

    set_img(1);
    drive_frame(0, 0, 0, 0, -1, -1);
    chk("imp_centre", 32'(cap[10][10]), 52);
    chk("imp_right", 32'(cap[10][12]), 31);
    chk("imp_below", 32'(cap[12][10]), 31);
    chk("imp_above", 32'(cap[8][10]), 31);
    chk("imp_left", 32'(cap[10][8]), 31);
    chk("imp_gr", 32'(cap[10][11]), 0);

    set_img(2);
    drive_frame(3, 1, 0, 0, -1, -1);
    chk("bypass_c5_7", 32'(cap[5][7]), 7);

    set_img(3);
    drive_frame(1, 1, 1, 0, -1, -1);
    set_img(3);
    drive_frame(2, 2, 0, 1, -1, -1);

    set_img(1);
    drive_frame(0, 0, 0, 0, 2, -1);
    chk("latch_keeps_sigma1", 32'(cap[10][10]), 52);
    drive_frame(2, 0, 0, 0, -1, -1);
    chk("next_frame_sigma3", 32'(cap[10][10]), 30);
    set_img(0);
    drive_frame(2, 0, 0, 0, -1, -1);
    chk("flat_sigma3", 32'(cap[6][6]), 99);

    drive_frame(0, 0, 0, 0, -1, 5);
    drive_frame(0, 0, 0, 0, -1, -1);
    chk("post_reset_c22", 32'(cap[2][2]), 99);

    set_img(3);
    drive_frame(0, 3, 1, 0, -1, -1);

    chk("sb_drained", 32'(sb_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
